// File: rtl/decoder_rr_arbiter.sv
// -----------------------------------------------------------------------------
// decoder_rr_arbiter
//
// Round-robin arbiter that lets 16 requesters share a single 4-to-16 select
// decoder. One active requester is chosen and its index is driven onto the
// decoder select lines {a,b,c,d}. A registered one-hot grant is produced
// alongside it. Every grant is followed by one turnaround cycle with no grant,
// so two requesters can never be granted in the same or adjacent cycles.
//
// Optional feature (compile-time macro ARB_QUANTUM_EN):
//   When defined, a grant is preempted after QUANTUM consecutive cycles if
//   another requester is waiting. When undefined, no counter is built and a
//   grant is held until its owner drops its request.
//
// Parameters:
//   QUANTUM    maximum consecutive grant cycles before preemption (2..255),
//              used only with ARB_QUANTUM_EN
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   req[15:0]  request vector, bit i = requester i wants the resource
//   a,b,c,d    registered select index of the granted requester (a = MSB)
//   gnt[15:0]  registered one-hot grant, zero when nobody is granted
//   gnt_valid  high while gnt is non-zero
// -----------------------------------------------------------------------------
module decoder_rr_arbiter #(
  parameter int unsigned QUANTUM = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic [15:0] gnt,
  output logic        gnt_valid
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // Round-robin search: first asserted bit scanning upward from last+1,
  // wrapping 15->0, with index `last` itself examined last. The loop runs
  // from the farthest candidate to the nearest so the nearest hit is the
  // final assignment. Result is {found, index}.
  function automatic logic [4:0] rr_pick(input logic [15:0] req_v,
                                         input logic [3:0]  last_v);
    logic [4:0] pick;
    logic [3:0] idx;
    pick = 5'd0;
    for (int k = 16; k >= 1; k--) begin
      idx = last_v + 4'(k);
      if (req_v[idx]) begin
        pick = {1'b1, idx};
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  logic [1:0]  state_r, state_s;
  logic [3:0]  last_r, last_s;
  logic [3:0]  sel_r, sel_s;
  logic [15:0] gnt_r, gnt_s;
  logic        gnt_valid_r, gnt_valid_s;
  logic [4:0]  pick_s;

`ifdef ARB_QUANTUM_EN
  localparam logic [7:0] QLIMIT = 8'(QUANTUM - 1);
  logic [7:0] qcnt_r, qcnt_s;
  logic       others_s;
`endif

  // Winner of the round-robin search, evaluated every cycle from the pointer.
  always_comb begin
    pick_s = rr_pick(req, last_r);
  end

`ifdef ARB_QUANTUM_EN
  // Any requester other than the current owner waiting (owner index is last_r).
  always_comb begin
    others_s = |(req & ~(16'd1 << last_r));
  end
`endif

  // Next-state and next-output logic for the IDLE / GRANT / GAP sequence.
  always_comb begin
    state_s     = state_r;
    last_s      = last_r;
    sel_s       = sel_r;
    gnt_s       = gnt_r;
    gnt_valid_s = gnt_valid_r;
`ifdef ARB_QUANTUM_EN
    qcnt_s      = qcnt_r;
`endif
    case (state_r)
      // IDLE and GAP make the same decision; they differ only in name.
      ST_IDLE, ST_GAP: begin
        if (pick_s[4]) begin
          state_s     = ST_GRANT;
          last_s      = pick_s[3:0];
          sel_s       = pick_s[3:0];
          gnt_s       = 16'd1 << pick_s[3:0];
          gnt_valid_s = 1'b1;
`ifdef ARB_QUANTUM_EN
          qcnt_s      = 8'd0;
`endif
        end else begin
          state_s     = ST_IDLE;
          gnt_s       = 16'h0000;
          gnt_valid_s = 1'b0;
        end
      end
      ST_GRANT: begin
        // While granted, last_r is the owner's index.
        if (!req[last_r]) begin
          state_s     = ST_GAP;
          gnt_s       = 16'h0000;
          gnt_valid_s = 1'b0;
        end
`ifdef ARB_QUANTUM_EN
        else if ((qcnt_r == QLIMIT) && others_s) begin
          state_s     = ST_GAP;
          gnt_s       = 16'h0000;
          gnt_valid_s = 1'b0;
        end else begin
          state_s = ST_GRANT;
          // Saturate so a lone owner keeps its grant indefinitely.
          if (qcnt_r != QLIMIT) begin
            qcnt_s = qcnt_r + 8'd1;
          end else begin
            qcnt_s = qcnt_r;
          end
        end
`else
        else begin
          state_s = ST_GRANT;
        end
`endif
      end
      default: begin
        state_s     = ST_IDLE;
        gnt_s       = 16'h0000;
        gnt_valid_s = 1'b0;
      end
    endcase
  end

  // State, pointer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      last_r      <= 4'd15;
      sel_r       <= 4'd0;
      gnt_r       <= 16'h0000;
      gnt_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      last_r      <= last_s;
      sel_r       <= sel_s;
      gnt_r       <= gnt_s;
      gnt_valid_r <= gnt_valid_s;
    end
  end

`ifdef ARB_QUANTUM_EN
  // Quantum counter: cycles spent in the current grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qcnt_r <= 8'd0;
    end else begin
      qcnt_r <= qcnt_s;
    end
  end
`endif

  assign {a, b, c, d} = sel_r;
  assign gnt          = gnt_r;
  assign gnt_valid    = gnt_valid_r;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_decoder_rr_arbiter
//
// Self-checking bench for decoder_rr_arbiter. A reference model predicts the
// outputs after every rising edge and queues them; an independent monitor
// pops and compares one entry per cycle. Directed sequences cover reset,
// single requester, round-robin wrap, quantum behaviour and asynchronous
// reset, followed by randomized request traffic.
// -----------------------------------------------------------------------------
module tb_decoder_rr_arbiter;

  localparam int unsigned QUANTUM = 4;
`ifdef ARB_QUANTUM_EN
  localparam bit Q_ON = 1'b1;
`else
  localparam bit Q_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic        a, b, c, d;
  logic [15:0] gnt;
  logic        gnt_valid;

  decoder_rr_arbiter #(.QUANTUM(QUANTUM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: owner = -1 when nobody holds the resource.
  int m_owner;
  int m_last;
  int m_run;
  int m_sel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: after each edge, who owns the resource?
  initial begin : model
    exp_t e;
    bit   others;
    bit   found;
    int   idx;
    m_owner = -1; m_last = 15; m_run = 0; m_sel = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_owner = -1; m_last = 15; m_run = 0; m_sel = 0;
        exp_q.delete();
      end else begin
        if (m_owner >= 0) begin
          others = (req & ~(16'd1 << m_owner)) != 16'd0;
          if (!req[m_owner]) begin
            m_owner = -1;
          end else if (Q_ON && m_run >= int'(QUANTUM) && others) begin
            m_owner = -1;
          end else begin
            m_run++;
          end
        end else begin
          found = 1'b0;
          for (int k = 1; k <= 16; k++) begin
            idx = (m_last + k) % 16;
            if (!found && req[idx]) begin
              found   = 1'b1;
              m_owner = idx;
            end
          end
          if (found) begin
            m_last = m_owner;
            m_sel  = m_owner;
            m_run  = 1;
          end
        end
        e.gnt   = (m_owner >= 0) ? (16'd1 << m_owner) : 16'd0;
        e.sel   = 4'(m_sel);
        e.valid = (m_owner >= 0);
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: compare DUT outputs against the model once per cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_gnt", 32'(gnt), 32'(e.gnt));
        check("sb_sel", 32'({a, b, c, d}), 32'(e.sel));
        check("sb_valid", 32'(gnt_valid), 32'(e.valid));
      end
    end
  end

  // Wait (bounded) for a grant; returns its index and the zero cycles seen.
  task automatic wait_grant(output int idx, output int zeros);
    bit got;
    got   = 1'b0;
    zeros = 0;
    idx   = -1;
    for (int i = 0; i < 20; i++) begin
      if (!got) begin
        @(negedge clk);
        if (gnt_valid) begin
          got = 1'b1;
          idx = int'({a, b, c, d});
        end else begin
          zeros++;
        end
      end
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_grant: got no grant expected grant within 20 cycles");
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stim
    int idx;
    int zeros;
    int rr_order[4];
    logic [15:0] exp_g;
    rr_order[0] = 0; rr_order[1] = 1; rr_order[2] = 15; rr_order[3] = 0;

    // Reset with every requester active.
    rst_n = 1'b0;
    req   = 16'hFFFF;
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_valid", 32'(gnt_valid), 32'h0);
    check("rst_sel", 32'({a, b, c, d}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_gnt", 32'(gnt), 32'h0001);
    check("first_sel", 32'({a, b, c, d}), 32'h0);

    // Single requester from IDLE.
    req = 16'h0000;
    repeat (3) @(negedge clk);
    req = 16'h0400;
    @(negedge clk);
    check("single_gnt", 32'(gnt), 32'h0400);
    check("single_sel", 32'({a, b, c, d}), 32'hA);
    req = 16'h0000;
    @(negedge clk);
    check("single_gap", 32'(gnt), 32'h0);
    @(negedge clk);
    check("single_idle", 32'(gnt_valid), 32'h0);

    // Round-robin with wrap: grant order 0, 1, 15, 0, one idle cycle each.
    pulse_reset();
    req = 16'h8003;
    for (int g = 0; g < 4; g++) begin
      wait_grant(idx, zeros);
      check("rr_order", 32'(idx), 32'(rr_order[g]));
      check("rr_latency", 32'(zeros), 32'h0);
      if (idx >= 0) begin
        repeat (2) @(negedge clk);
        req[idx] = 1'b0;
        @(negedge clk);
        check("rr_gap", 32'(gnt), 32'h0);
        req[idx] = 1'b1;
      end
    end

    // Requesters 2 and 5 held: quantum rotation, or 2 holds without it.
    pulse_reset();
    req = 16'h0024;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (Q_ON) begin
        exp_g = (i % 5 == 4) ? 16'h0000 : (((i / 5) % 2 == 0) ? 16'h0004 : 16'h0020);
      end else begin
        exp_g = 16'h0004;
      end
      check("quantum_seq", 32'(gnt), 32'(exp_g));
    end
    // Only requester 2 left: it keeps the grant.
    req = 16'h0004;
    repeat (12) @(negedge clk);
    check("lone_hold", 32'(gnt), 32'h0004);

    // Asynchronous reset while requester 5 owns the resource.
    pulse_reset();
    req = 16'h0020;
    @(negedge clk);
    check("pre_rst_gnt", 32'(gnt), 32'h0020);
    req = 16'h0021;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_gnt", 32'(gnt), 32'h0);
    check("async_rst_valid", 32'(gnt_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_gnt", 32'(gnt), 32'h0001);

    // Randomized traffic: sparse toggling of request bits.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      req = req ^ 16'($urandom & $urandom & $urandom);
    end
    req = 16'h0000;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
